// File: rtl/controle_busca_if.sv
// controle_busca_if: instruction-memory read bus plus the held-instruction handoff to decode.
interface controle_busca_if #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
);
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_endereco;
  logic               mem_pronto;
  logic [INSTR_W-1:0] mem_dado;
  logic               instr_valida;
  logic [INSTR_W-1:0] instrucao;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_aceita;
  logic               branch;
  logic [ADDR_W-1:0]  imm;
  modport master (
    output mem_req, mem_endereco, instr_valida, instrucao, instr_pc,
    input  mem_pronto, mem_dado, instr_aceita, branch, imm
  );
  modport slave (
    input  mem_req, mem_endereco, instr_valida, instrucao, instr_pc,
    output mem_pronto, mem_dado, instr_aceita, branch, imm
  );
endinterface

// File: rtl/controle_busca.sv
// controle_busca: multicycle fetch sequencer owning the PC, with halt, backpressure and memory timeout.
module controle_busca #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               inicia,
  input  logic               parar,
  controle_busca_if.master   bus,
  output logic               ocupado,
  output logic               erro
);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {PARADO, BUSCA, ENTREGA, ERRO} estado_t;
  estado_t            estado, estado_n;
  logic [ADDR_W-1:0]  pc, pc_n, ipc, ipc_n;
  logic [INSTR_W-1:0] instr, instr_n;
  logic [TW-1:0]      timer, timer_n;
  // timer defaults to zero so every entry into BUSCA starts a fresh wait window
  always_comb begin
    estado_n = estado;
    pc_n     = pc;
    ipc_n    = ipc;
    instr_n  = instr;
    timer_n  = '0;
    case (estado)
      PARADO:  if (inicia && !parar) estado_n = BUSCA;
      BUSCA:
        if (bus.mem_pronto) begin
          estado_n = ENTREGA;
          instr_n  = bus.mem_dado;
          ipc_n    = pc;
        end else if (timer == TW'(TIMEOUT - 1)) estado_n = ERRO;
        else timer_n = timer + TW'(1);
      ENTREGA:
        if (bus.instr_aceita) begin
          pc_n     = bus.branch ? ipc + bus.imm : ipc + ADDR_W'(1);
          estado_n = parar ? PARADO : BUSCA;
        end
      default: ;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= PARADO;
      pc     <= '0;
      ipc    <= '0;
      instr  <= '0;
      timer  <= '0;
    end else begin
      estado <= estado_n;
      pc     <= pc_n;
      ipc    <= ipc_n;
      instr  <= instr_n;
      timer  <= timer_n;
    end
  end
  assign bus.mem_req      = estado == BUSCA;
  assign bus.mem_endereco = pc;
  assign bus.instr_valida = estado == ENTREGA;
  assign bus.instrucao    = instr;
  assign bus.instr_pc     = ipc;
  assign ocupado          = estado == BUSCA || estado == ENTREGA;
  assign erro             = estado == ERRO;
endmodule

// File: tb/tb_controle_busca.sv
// tb_controle_busca: directed plan plus randomized traffic against a transaction-level fetch model.
module tb_controle_busca;
  localparam int TIMEOUT = 16;
  localparam int M_PARADO = 0, M_BUSCA = 1, M_ENTREGA = 2, M_ERRO = 3;
  logic clock = 1'b0, reset = 1'b1, inicia = 1'b0, parar = 1'b0;
  logic ocupado, erro;
  int n_tests = 0, n_fail = 0;
  int m_mode = M_PARADO, m_wait = 0;
  logic [63:0] m_pc = '0, m_ipc = '0;
  logic [31:0] m_word = '0;
  controle_busca_if #(.ADDR_W(64), .INSTR_W(32)) bus ();
  controle_busca #(.ADDR_W(64), .INSTR_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .inicia(inicia), .parar(parar),
    .bus(bus), .ocupado(ocupado), .erro(erro)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic verifica();
    chk("mem_req", bus.mem_req, m_mode == M_BUSCA);
    chk("instr_valida", bus.instr_valida, m_mode == M_ENTREGA);
    chk("erro", erro, m_mode == M_ERRO);
    chk("ocupado", ocupado, m_mode == M_BUSCA || m_mode == M_ENTREGA);
    chk("mem_endereco", bus.mem_endereco, m_pc);
    if (m_mode == M_ENTREGA) begin
      chk("instrucao", bus.instrucao, m_word);
      chk("instr_pc", bus.instr_pc, m_ipc);
    end
  endtask
  // one clock: drive inputs, advance the model, then compare just after the edge
  task automatic passo(input logic ini, input logic par, input logic pro, input logic [31:0] dad,
                       input logic ace, input logic br, input logic [63:0] im);
    inicia = ini; parar = par; bus.mem_pronto = pro; bus.mem_dado = dad;
    bus.instr_aceita = ace; bus.branch = br; bus.imm = im;
    if (reset) begin
      m_mode = M_PARADO; m_pc = '0; m_ipc = '0; m_word = '0; m_wait = 0;
    end else if (m_mode == M_PARADO) begin
      if (ini && !par) begin m_mode = M_BUSCA; m_wait = 0; end
    end else if (m_mode == M_BUSCA) begin
      if (pro) begin
        m_mode = M_ENTREGA; m_word = dad; m_ipc = m_pc;
      end else begin
        m_wait++;
        if (m_wait == TIMEOUT) m_mode = M_ERRO;
      end
    end else if (m_mode == M_ENTREGA && ace) begin
      m_pc = br ? m_ipc + im : m_ipc + 64'd1;
      m_mode = par ? M_PARADO : M_BUSCA;
      m_wait = 0;
    end
    @(posedge clock);
    #1;
    verifica();
  endtask
  task automatic ciclo_instr(input logic par, input logic br, input logic [63:0] im);
    passo(1'b0, 1'b0, 1'b1, $urandom, 1'b0, 1'b0, 64'd0);
    passo(1'b0, par, 1'b0, $urandom, 1'b1, br, im);
  endtask
  task automatic reinicia();
    reset = 1'b1;
    passo(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
    reset = 1'b0;
    passo(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
  endtask
  task automatic aleatorio(input int p_pronto);
    longint d;
    logic [63:0] im;
    d = longint'($urandom_range(0, 40)) - 20;
    im = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom} : d;
    reset = ($urandom_range(0, 149) == 0);
    passo($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 99) < p_pronto,
          $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, im);
    reset = 1'b0;
  endtask
  initial begin
    passo(1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 64'd0);
    reset = 1'b0;
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_valida", bus.instr_valida, 1'b0);
    chk("rst_ocupado", ocupado, 1'b0);
    chk("rst_erro", erro, 1'b0);
    chk("rst_endereco", bus.mem_endereco, 64'd0);
    chk("rst_instrucao", bus.instrucao, 32'd0);
    chk("rst_instr_pc", bus.instr_pc, 64'd0);
    passo(1'b1, 1'b0, 1'b1, $urandom, 1'b1, 1'b0, 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("t1_endereco", bus.mem_endereco, 64'(i));
      chk("t1_ocupado", ocupado, 1'b1);
      passo(1'b0, 1'b0, 1'b1, $urandom, 1'b1, 1'b0, 64'd0);
      chk("t1_instr_pc", bus.instr_pc, 64'(i));
      passo(1'b0, 1'b0, 1'b1, $urandom, 1'b1, 1'b0, 64'd0);
    end
    reinicia();
    repeat (5) ciclo_instr(1'b0, 1'b0, 64'd0);
    chk("t2_pc5", bus.mem_endereco, 64'd5);
    ciclo_instr(1'b0, 1'b1, -64'sd2);
    chk("t2_menos2", bus.mem_endereco, 64'd3);
    ciclo_instr(1'b0, 1'b1, 64'd10);
    chk("t2_mais10", bus.mem_endereco, 64'd13);
    reinicia();
    ciclo_instr(1'b0, 1'b1, -64'sd1);
    chk("t3_wrap", bus.mem_endereco, 64'hFFFF_FFFF_FFFF_FFFF);
    ciclo_instr(1'b0, 1'b0, 64'd0);
    chk("t3_volta", bus.mem_endereco, 64'd0);
    reinicia();
    repeat (TIMEOUT) passo(1'b0, 1'b0, 1'b0, $urandom, 1'b0, 1'b0, 64'd0);
    chk("t4_erro", erro, 1'b1);
    chk("t4_req", bus.mem_req, 1'b0);
    repeat (5) passo(1'b1, 1'b0, 1'b1, $urandom, 1'b1, 1'b1, 64'd5);
    chk("t4_sticky", erro, 1'b1);
    reinicia();
    repeat (TIMEOUT - 1) passo(1'b0, 1'b0, 1'b0, $urandom, 1'b0, 1'b0, 64'd0);
    passo(1'b0, 1'b0, 1'b1, 32'hCAFE_0016, 1'b0, 1'b0, 64'd0);
    chk("t4_sem_erro", erro, 1'b0);
    chk("t4_entregue", bus.instrucao, 32'hCAFE_0016);
    repeat (5) begin
      passo(1'b0, 1'b1, $urandom_range(0, 1), $urandom, 1'b0, 1'b1, {$urandom, $urandom});
      chk("t5_valida", bus.instr_valida, 1'b1);
      chk("t5_instrucao", bus.instrucao, 32'hCAFE_0016);
      chk("t5_instr_pc", bus.instr_pc, 64'd0);
      chk("t5_req", bus.mem_req, 1'b0);
    end
    passo(1'b0, 1'b0, 1'b0, $urandom, 1'b1, 1'b0, 64'd0);
    chk("t5_prox", bus.mem_endereco, 64'd1);
    reinicia();
    repeat (7) ciclo_instr(1'b0, 1'b0, 64'd0);
    ciclo_instr(1'b1, 1'b0, 64'd0);
    chk("t6_parado", ocupado, 1'b0);
    chk("t6_pc8", bus.mem_endereco, 64'd8);
    passo(1'b1, 1'b1, 1'b1, $urandom, 1'b1, 1'b0, 64'd0);
    chk("t6_prioridade", ocupado, 1'b0);
    passo(1'b1, 1'b0, 1'b0, $urandom, 1'b0, 1'b0, 64'd0);
    chk("t6_retoma_req", bus.mem_req, 1'b1);
    chk("t6_retoma_pc", bus.mem_endereco, 64'd8);
    reset = 1'b1;
    passo(1'b0, 1'b0, 1'b1, $urandom, 1'b0, 1'b0, 64'd0);
    reset = 1'b0;
    chk("t6_rst_req", bus.mem_req, 1'b0);
    chk("t6_rst_pc", bus.mem_endereco, 64'd0);
    for (int s = 0; s < 4; s++)
      repeat (1000) aleatorio(s == 1 ? 5 : s == 2 ? 100 : 50);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/controle_busca.md
Name: controle_busca

Overview:
Multicycle fetch sequencer that owns the program counter. It issues word-addressed reads to instruction memory over a req/ready handshake and holds each fetched instruction until the datapath accepts it. It then advances the PC by +1, or by a signed branch offset relative to the instruction's own PC. It sits between instruction memory and decode, and replaces a free-running PC with start, halt, backpressure and timeout control.

Parameters:
ADDR_W, 64, width of PC, memory address and branch offset
INSTR_W, 32, instruction word width
TIMEOUT, 16, maximum cycles in BUSCA waiting for mem_pronto before raising erro (must be >= 2)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
inicia  in  1  start/resume fetching from PARADO
parar  in  1  halt request, sampled only with an accepted instruction or in PARADO
mem_req  out  1  read request to instruction memory
mem_endereco  out  ADDR_W  word address of the read (current PC)
mem_pronto  in  1  memory data valid this cycle
mem_dado  in  INSTR_W  instruction word from memory
instr_valida  out  1  instrucao/instr_pc valid for decode
instrucao  out  INSTR_W  held instruction
instr_pc  out  ADDR_W  PC of held instruction
instr_aceita  in  1  decode consumes the instruction this cycle
branch  in  1  taken branch for the accepted instruction, valid with instr_aceita
imm  in  ADDR_W  signed word offset, valid with branch
ocupado  out  1  high in BUSCA or ENTREGA
erro  out  1  memory timeout, sticky until reset

Behaviour:
- Reset (any state, any cycle, including mid-handshake):
  - state=PARADO, pc=0, timer=0.
  - instrucao=0, instr_pc=0.
  - mem_req=0, instr_valida=0, ocupado=0, erro=0, all from the next edge.
- States: PARADO, BUSCA, ENTREGA, ERRO. All outputs are decoded from registered state.
  - mem_req=1 only in BUSCA.
  - instr_valida=1 only in ENTREGA.
  - erro=1 only in ERRO.
- mem_endereco = pc at all times.
- PARADO:
  - inicia=1 and parar=0 -> BUSCA.
  - parar has priority; pc is unchanged.
- BUSCA:
  - timer is cleared on entry.
  - mem_pronto=1 -> instrucao<=mem_dado, instr_pc<=pc, -> ENTREGA.
  - mem_pronto=0 and timer==TIMEOUT-1 -> ERRO.
  - Otherwise timer++.
  - A mem_pronto arriving on the TIMEOUT-th BUSCA cycle is accepted. parar is ignored in this state.
- ENTREGA:
  - instrucao and instr_pc are held stable until instr_aceita=1.
  - On accept, pc <= branch ? instr_pc + imm : instr_pc + 1.
  - All arithmetic is two's complement modulo 2^ADDR_W; wrap-around is silent.
  - After accept: parar=1 -> PARADO (pc is still updated), else -> BUSCA.
  - branch, imm and parar are ignored while instr_aceita=0.
- ERRO:
  - mem_req=0, instr_valida=0.
  - Inputs are ignored; only reset exits.
- mem_pronto outside BUSCA is ignored; a late memory response never updates instrucao.
- Latency: at least 2 cycles per instruction (1 BUSCA + 1 ENTREGA). mem_req deasserts the cycle after mem_pronto.
- No instruction is dropped or duplicated under any instr_aceita pattern.

Test Plan:
1. Reset, inicia pulse, memory answers in the same cycle, instr_aceita tied 1, branch=0 -> mem_endereco 0,1,2,3 on alternate cycles; instr_pc matches; ocupado=1.
2. Accept with branch=1:
   - instr_pc=5, imm=-2 -> next mem_endereco=3.
   - Then instr_pc=3, imm=+10 -> mem_endereco=13.
3. instr_pc=0, branch=1, imm=-1 -> mem_endereco=0xFFFFFFFFFFFFFFFF; the next non-branch accept -> mem_endereco=0.
4. Hold mem_pronto=0:
   - For 16 cycles -> erro=1 on the following cycle, mem_req=0; erro persists until reset.
   - Repeat with mem_pronto on the 16th BUSCA cycle -> erro stays 0 and the instruction is delivered.
5. Hold instr_aceita=0 for 5 cycles in ENTREGA while mem_pronto/mem_dado toggle -> instr_valida=1 and instrucao/instr_pc unchanged throughout; mem_req=0.
6. Halt, resume and reset:
   - Accept with parar=1 at instr_pc=7 -> PARADO with pc=8; inicia -> fetch resumes at 8.
   - Assert reset during BUSCA -> mem_req=0 and pc=0 next cycle.
